// File: rtl/ponte_sinc_somador_if.sv
// Bus bundle between the clocked bridge and its surroundings: the binary side
// (operand in, sum out), the dual-rail stage side (rails, ack, soma) and the error flags.
interface ponte_sinc_somador_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic       in_cin;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] opr;
    logic       ack;
    logic [7:0] soma;
    logic       ack_next;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_sum;
    logic       err_timeout;
    logic       err_illegal;

    modport master (
        output in_valid, in_a, in_b, in_cin, ack, soma, out_ready,
        input  in_ready, a, b, opr, ack_next, out_valid, out_sum, err_timeout, err_illegal
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, ack, soma, out_ready,
        output in_ready, a, b, opr, ack_next, out_valid, out_sum, err_timeout, err_illegal
    );
endinterface

// File: rtl/ponte_sinc_somador.sv
// Clocked bridge around a dual-rail 4-bit adder stage; operand accept to DATA on rails is 1 cycle.
// Backpressure: in_ready drops until the NULL wavefront returns; a full output buffer holds ack_next low.
module ponte_sinc_somador #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ponte_sinc_somador_if.slave  bus
);
    localparam int             CW   = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [CW-1:0]  TMAX = CW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {F_IDLE, F_DATA, F_NULL} feed_t;
    typedef enum logic       {C_DATA, C_NULL}         coll_t;

    feed_t                  fst;
    coll_t                  cst;
    logic [SYNC_STAGES-1:0] ack_sync, det_sync, nul_sync;
    logic                   ack_s, det_s, nul_s;
    logic                   det_raw, nul_raw, ill_raw;
    logic [3:0]             dec;
    logic [CW-1:0]          f_cnt, c_cnt;
    logic                   f_to, c_to;
    logic                   f_hold, c_hold;

    function automatic logic [7:0] enc4(input logic [3:0] x);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[2*i+1] = x[i];
            r[2*i]   = ~x[i];
        end
        return r;
    endfunction

    // Completion and decode look at the raw stage outputs; only the synchronised
    // flags feed decisions, by which time soma has been stable for SYNC_STAGES cycles.
    always_comb begin
        det_raw = 1'b1;
        ill_raw = 1'b0;
        dec     = '0;
        for (int i = 0; i < 4; i++) begin
            det_raw = det_raw & (bus.soma[2*i +: 2] != 2'b00);
            ill_raw = ill_raw | (bus.soma[2*i +: 2] == 2'b11);
            dec[i]  = bus.soma[2*i+1];
        end
    end

    assign nul_raw = (bus.soma == 8'h00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_sync <= '0;
            det_sync <= '0;
            nul_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], bus.ack};
            det_sync <= {det_sync[SYNC_STAGES-2:0], det_raw};
            nul_sync <= {nul_sync[SYNC_STAGES-2:0], nul_raw};
        end
    end

    assign ack_s = ack_sync[SYNC_STAGES-1];
    assign det_s = det_sync[SYNC_STAGES-1];
    assign nul_s = nul_sync[SYNC_STAGES-1];

    // A hold cycle is a waiting cycle with no state change; anything else clears the counter.
    assign f_hold = ((fst == F_DATA) && !ack_s) || ((fst == F_NULL) && ack_s);
    assign c_hold = (cst == C_NULL) && !nul_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fst          <= F_IDLE;
            bus.a        <= '0;
            bus.b        <= '0;
            bus.opr      <= '0;
            bus.in_ready <= 1'b1;
            f_cnt        <= '0;
            f_to         <= 1'b0;
        end else begin
            case (fst)
                F_IDLE: if (bus.in_valid) begin
                    bus.a        <= enc4(bus.in_a);
                    bus.b        <= enc4(bus.in_b);
                    bus.opr      <= {bus.in_cin, ~bus.in_cin};
                    bus.in_ready <= 1'b0;
                    fst          <= F_DATA;
                end
                F_DATA: if (ack_s) begin
                    bus.a   <= '0;
                    bus.b   <= '0;
                    bus.opr <= '0;
                    fst     <= F_NULL;
                end
                F_NULL: if (!ack_s) begin
                    bus.in_ready <= 1'b1;
                    fst          <= F_IDLE;
                end
                default: fst <= F_IDLE;
            endcase
            if (!f_hold) begin
                f_cnt <= '0;
            end else if (f_cnt != TMAX) begin
                f_cnt <= f_cnt + 1'b1;
                if (f_cnt + 1'b1 == TMAX) f_to <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cst             <= C_DATA;
            bus.out_valid   <= 1'b0;
            bus.out_sum     <= '0;
            bus.ack_next    <= 1'b0;
            bus.err_illegal <= 1'b0;
            c_cnt           <= '0;
            c_to            <= 1'b0;
        end else begin
            if (bus.out_valid && bus.out_ready) bus.out_valid <= 1'b0;
            case (cst)
                C_DATA: if (det_s && (!bus.out_valid || bus.out_ready)) begin
                    bus.out_sum   <= dec;
                    bus.out_valid <= 1'b1;
                    bus.ack_next  <= 1'b1;
                    if (ill_raw) bus.err_illegal <= 1'b1;
                    cst           <= C_NULL;
                end
                C_NULL: if (nul_s) begin
                    bus.ack_next <= 1'b0;
                    cst          <= C_DATA;
                end
                default: cst <= C_DATA;
            endcase
            if (!c_hold) begin
                c_cnt <= '0;
            end else if (c_cnt != TMAX) begin
                c_cnt <= c_cnt + 1'b1;
                if (c_cnt + 1'b1 == TMAX) c_to <= 1'b1;
            end
        end
    end

    assign bus.err_timeout = f_to | c_to;
endmodule

// File: tb/tb_ponte_sinc_somador.sv
// Bench for ponte_sinc_somador: a behavioural dual-rail adder stage plus a sum scoreboard,
// directed corner cases followed by randomized operands and consumer backpressure.
module tb_ponte_sinc_somador;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ponte_sinc_somador_if bus ();

    ponte_sinc_somador #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         vectors = 0;
    int         fails   = 0;
    logic [3:0] exp_q[$];
    bit         pend_rails = 0;
    logic [7:0] exp_a, exp_b;
    logic [1:0] exp_opr;
    bit         stage_freeze = 0, stage_jitter = 0, inject = 0, rand_on = 0;
    bit         stage_full;
    logic [3:0] stage_sum, da, db;

    function automatic logic [7:0] enc4(input logic [3:0] x);
        logic [7:0] r;
        for (int i = 0; i < 4; i++) r[2*i +: 2] = x[i] ? 2'b10 : 2'b01;
        return r;
    endfunction

    function automatic bit complete(input logic [7:0] v);
        for (int i = 0; i < 4; i++) if (v[2*i +: 2] == 2'b00) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [3:0] true_rails(input logic [7:0] v);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = v[2*i+1];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] x, input logic [3:0] y, input logic c);
        int n = 0;
        bus.in_a = x; bus.in_b = y; bus.in_cin = c; bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 200) begin tick(); n++; end
        if (n >= 200) check("send_accept_timeout", 0, 1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int n = 0;
        while (!bus.out_valid && n < 200) begin tick(); n++; end
        if (n >= 200) check("out_valid_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!bus.in_ready && n < 200) begin tick(); n++; end
        if (n >= 200) check("in_ready_timeout", 0, 1);
    endtask

    // Asynchronous adder stage: latches DATA when its inputs are complete and the
    // consumer asked for data, returns to NULL when inputs are NULL and DATA was consumed.
    initial begin
        bus.soma = '0; bus.ack = 1'b0; stage_full = 0;
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                bus.soma = '0; bus.ack = 1'b0; stage_full = 0;
            end else if (!stage_freeze && !(stage_jitter && $urandom_range(0, 2) == 0)) begin
                if (!stage_full && complete(bus.a) && complete(bus.b) && bus.opr != 2'b00
                    && !bus.ack_next) begin
                    da = true_rails(bus.a);
                    db = true_rails(bus.b);
                    stage_sum = da + db + {3'b000, bus.opr[1]};
                    bus.soma = enc4(stage_sum) | (inject ? 8'h03 : 8'h00);
                    bus.ack = 1'b1; stage_full = 1;
                end else if (stage_full && bus.a == 8'h00 && bus.b == 8'h00 && bus.opr == 2'b00
                             && bus.ack_next) begin
                    bus.soma = '0; bus.ack = 1'b0; stage_full = 0;
                end
            end
        end
    end

    // Scoreboard: every accepted operand yields one sum; rails must carry its code one cycle on.
    always @(negedge clk) begin
        logic [3:0] s;
        if (!rst_n) begin
            exp_q.delete();
            pend_rails = 0;
        end else begin
            if (pend_rails) begin
                check("rails_a", bus.a, exp_a);
                check("rails_b", bus.b, exp_b);
                check("rails_opr", bus.opr, exp_opr);
                pend_rails = 0;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) check("out_unexpected", 1, 0);
                else check("out_sum", bus.out_sum, exp_q.pop_front());
            end
            if (bus.in_valid && bus.in_ready) begin
                s = bus.in_a + bus.in_b + {3'b000, bus.in_cin};
                if (inject) s[0] = 1'b1;
                exp_q.push_back(s);
                exp_a = enc4(bus.in_a);
                exp_b = enc4(bus.in_b);
                exp_opr = {bus.in_cin, ~bus.in_cin};
                pend_rails = 1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_cin = 1'b0;
        bus.out_ready = 1'b0;
        tick(3);
        check("rst_a", bus.a, 0);
        check("rst_b", bus.b, 0);
        check("rst_opr", bus.opr, 0);
        check("rst_ack_next", bus.ack_next, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_sum", bus.out_sum, 0);
        check("rst_err_timeout", bus.err_timeout, 0);
        check("rst_err_illegal", bus.err_illegal, 0);
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", bus.in_ready, 1);

        send(4'd5, 4'd9, 1'b1);
        check("add_a", bus.a, 8'h66);
        check("add_b", bus.b, 8'h96);
        check("add_opr", bus.opr, 2'b10);
        wait_out();
        check("add_out_valid", bus.out_valid, 1);
        check("add_sum", bus.out_sum, 4'hF);
        bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
        wait_idle();
        check("add_null_a", bus.a, 0);
        check("add_null_opr", bus.opr, 0);
        check("add_no_timeout", bus.err_timeout, 0);
        check("add_no_illegal", bus.err_illegal, 0);

        send(4'd15, 4'd1, 1'b0);
        wait_out();
        check("wrap_sum", bus.out_sum, 4'h0);
        bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
        wait_idle();

        stage_freeze = 1;
        send(4'd2, 4'd3, 1'b1);
        tick(7);
        check("timeout_early", bus.err_timeout, 0);
        tick();
        check("timeout_at_8", bus.err_timeout, 1);
        stage_freeze = 0;
        wait_out();
        check("timeout_flow_sum", bus.out_sum, 4'd6);
        check("timeout_sticky", bus.err_timeout, 1);
        bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
        wait_idle();

        send(4'd3, 4'd4, 1'b0);
        wait_out();
        check("bp_first_sum", bus.out_sum, 4'd7);
        wait_idle();
        send(4'd1, 4'd1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("bp_ack_next_low", bus.ack_next, 0);
            check("bp_sum_held", bus.out_sum, 4'd7);
        end
        bus.out_ready = 1'b1;
        tick();
        check("bp_second_valid", bus.out_valid, 1);
        check("bp_second_sum", bus.out_sum, 4'd2);
        tick(); bus.out_ready = 1'b0;
        wait_idle();

        check("pre_illegal", bus.err_illegal, 0);
        inject = 1;
        send(4'd4, 4'd3, 1'b0);
        wait_out();
        check("illegal_flag", bus.err_illegal, 1);
        check("illegal_sum", bus.out_sum, 4'd7);
        bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
        inject = 0;
        wait_idle();

        stage_freeze = 1;
        send(4'd1, 4'd2, 1'b0);
        tick(2);
        rst_n = 1'b0;
        #1;
        check("midrst_a", bus.a, 0);
        check("midrst_b", bus.b, 0);
        check("midrst_opr", bus.opr, 0);
        check("midrst_ack_next", bus.ack_next, 0);
        check("midrst_err_timeout", bus.err_timeout, 0);
        check("midrst_err_illegal", bus.err_illegal, 0);
        stage_freeze = 0;
        tick(2);
        rst_n = 1'b1;
        tick();
        check("midrst_in_ready", bus.in_ready, 1);

        stage_jitter = 1;
        rand_on = 1;
        fork
            while (rand_on) begin
                @(posedge clk); #1;
                if (rand_on) bus.out_ready = ($urandom_range(0, 2) != 0);
            end
        join_none
        for (int t = 0; t < 60; t++) begin
            send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            tick($urandom_range(0, 3));
        end
        rand_on = 0;
        tick(2);
        bus.out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin tick(); n++; end
        check("drain_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
